spi_input_controller: RTL and testbench

- SPI slave front end; sits directly upstream of the SPI output controller.
- Synchronizes the asynchronous SCK/SS/MOSI pins into the clk domain and detects SCK edges.
- Deserializes MOSI bytes (mode 0, MSB first) and decodes host commands.
- Streams image pixel bytes to the input buffer and supplies shift_SPI, sig_edge and SPI_in to the output controller.

---
 rtl/spi_input_controller.sv | 180 ++++++++++++++++++
 tb/tb_spi_input_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_input_controller.sv
// SPI slave front end: pin synchronizers, SCK edge detection, mode-0 byte
// deserializer and host command decode feeding the pixel input buffer.
module spi_input_controller #(
    parameter int NUM_PIXELS = 784,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              SCK,
    input  logic              SS,
    input  logic              MOSI,
    output logic              shift_SPI,
    output logic              sig_edge,
    output logic [7:0]        SPI_in,
    output logic              byte_done,
    output logic              cost_req,
    output logic [7:0]        pixel_data,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              pixel_wr,
    output logic              image_loaded
);

    typedef enum logic {
        CMD      = 1'b0,
        LOAD_PIX = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);

    // [0] metastability stage, [1] synchronized, [2] previous (edge detect)
    logic [2:0]        sck_q, sck_d;
    logic [2:0]        ss_q, ss_d;
    logic [2:0]        mosi_q, mosi_d;

    logic              shift_q, shift_d;
    logic              edge_q, edge_d;
    logic [7:0]        sr_q, sr_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        spi_in_q, spi_in_d;
    logic              bd_q, bd_d;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              wr_q, wr_d;
    logic              cost_q, cost_d;
    logic              last_q, last_d;
    logic              img_q, img_d;
    logic              abort_q, abort_d;

    logic              ss_rise;
    logic [7:0]        sr_next;

    assign ss_rise = ss_q[1] & ~ss_q[2];
    assign sr_next = {sr_q[6:0], mosi_q[2]};

    // Synchronizers, gated edge detection and the byte deserializer
    always_comb begin
        sck_d    = {sck_q[1:0], SCK};
        ss_d     = {ss_q[1:0], SS};
        mosi_d   = {mosi_q[1:0], MOSI};
        shift_d  = sck_q[1] & ~sck_q[2] & ~ss_q[1];
        edge_d   = ~sck_q[1] & sck_q[2] & ~ss_q[1];
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        spi_in_d = spi_in_q;
        bd_d     = 1'b0;
        if (ss_rise) begin
            cnt_d = 3'd0;
        end else if (shift_q) begin
            sr_d  = sr_next;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                spi_in_d = sr_next;
                bd_d     = 1'b1;
            end
        end
    end

    // Command decode and pixel streaming state machine
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        cost_d  = 1'b0;
        last_d  = 1'b0;
        img_d   = last_q;
        abort_d = 1'b0;
        case (state_q)
            CMD: begin
                if (bd_q) begin
                    if (spi_in_q == 8'h01) begin
                        cost_d = 1'b1;
                    end else if (spi_in_q == 8'h02) begin
                        addr_d  = '0;
                        idx_d   = '0;
                        state_d = LOAD_PIX;
                        abort_d = ss_rise;
                    end
                end
            end
            LOAD_PIX: begin
                if (bd_q) begin
                    wr_d   = 1'b1;
                    data_d = spi_in_q;
                    addr_d = idx_q;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        last_d  = 1'b1;
                        state_d = CMD;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        abort_d = ss_rise;
                    end
                end else if (ss_rise || abort_q) begin
                    idx_d   = '0;
                    state_d = CMD;
                end
            end
            default: state_d = CMD;
        endcase
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sck_q    <= '0;
            ss_q     <= '0;
            mosi_q   <= '0;
            shift_q  <= 1'b0;
            edge_q   <= 1'b0;
            sr_q     <= '0;
            cnt_q    <= '0;
            spi_in_q <= '0;
            bd_q     <= 1'b0;
            state_q  <= CMD;
            idx_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wr_q     <= 1'b0;
            cost_q   <= 1'b0;
            last_q   <= 1'b0;
            img_q    <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            sck_q    <= sck_d;
            ss_q     <= ss_d;
            mosi_q   <= mosi_d;
            shift_q  <= shift_d;
            edge_q   <= edge_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            spi_in_q <= spi_in_d;
            bd_q     <= bd_d;
            state_q  <= state_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_q     <= wr_d;
            cost_q   <= cost_d;
            last_q   <= last_d;
            img_q    <= img_d;
            abort_q  <= abort_d;
        end
    end

    assign shift_SPI    = shift_q;
    assign sig_edge     = edge_q;
    assign SPI_in       = spi_in_q;
    assign byte_done    = bd_q;
    assign cost_req     = cost_q;
    assign pixel_data   = data_q;
    assign pixel_addr   = addr_q;
    assign pixel_wr     = wr_q;
    assign image_loaded = img_q;

endmodule

// File: tb/tb_spi_input_controller.sv
// Directed bench for spi_input_controller with a 4-pixel image size.
// Strobes are counted and logged on the falling clock edge.
module tb_spi_input_controller;

    localparam int NP = 4;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          SCK = 1'b0;
    logic          SS = 1'b1;
    logic          MOSI = 1'b0;
    logic          shift_SPI, sig_edge, byte_done, cost_req;
    logic          pixel_wr, image_loaded;
    logic [7:0]    SPI_in, pixel_data;
    logic [AW-1:0] pixel_addr;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_bd, n_cost, n_wr, n_img, n_ovl;
    int bd_cyc, cost_cyc, wr_cyc, img_cyc;
    logic [7:0]    cost_spi;
    logic [AW-1:0] wa [8];
    logic [7:0]    wd [8];
    logic [4:0]    s;

    spi_input_controller #(.NUM_PIXELS(NP), .ADDR_W(AW)) dut (
        .clk(clk), .n_rst(n_rst), .SCK(SCK), .SS(SS), .MOSI(MOSI),
        .shift_SPI(shift_SPI), .sig_edge(sig_edge), .SPI_in(SPI_in),
        .byte_done(byte_done), .cost_req(cost_req),
        .pixel_data(pixel_data), .pixel_addr(pixel_addr),
        .pixel_wr(pixel_wr), .image_loaded(image_loaded)
    );

    always #5 clk = ~clk;

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor
    always @(negedge clk) begin
        if (byte_done) begin
            n_bd   = n_bd + 1;
            bd_cyc = cyc;
        end
        if (cost_req) begin
            n_cost   = n_cost + 1;
            cost_cyc = cyc;
            cost_spi = SPI_in;
        end
        if (pixel_wr) begin
            if (n_wr < 8) begin
                wa[n_wr] = pixel_addr;
                wd[n_wr] = pixel_data;
            end
            n_wr   = n_wr + 1;
            wr_cyc = cyc;
        end
        if (image_loaded) begin
            n_img   = n_img + 1;
            img_cyc = cyc;
        end
        if (int'(pixel_wr) + int'(cost_req) + int'(image_loaded) > 1)
            n_ovl = n_ovl + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        n_bd = 0; n_cost = 0; n_wr = 0; n_img = 0;
        bd_cyc = 0; cost_cyc = 0; wr_cyc = 0; img_cyc = 0;
        cost_spi = 8'h00;
    endtask

    task automatic do_reset();
        SCK = 1'b0;
        MOSI = 1'b0;
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        clr();
    endtask

    // Send the top n bits of b, MSB first, mode 0
    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            MOSI = b[7-i];
            #60 SCK = 1'b1;
            #60 SCK = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] b);
        spi_bits(b, 8);
        #100;
    endtask

    initial begin
        clr();
        n_ovl = 0;
        do_reset();

        // Reset state
        chk("rst_spi_in", 32'(SPI_in), 32'h00);
        chk("rst_strobes", {shift_SPI, sig_edge, byte_done, cost_req,
            pixel_wr, image_loaded}, 32'h0);
        chk("rst_addr", 32'(pixel_addr), 32'h0);
        chk("rst_data", 32'(pixel_data), 32'h0);

        // Reset mid-byte
        SS = 1'b0;
        repeat (5) @(negedge clk);
        spi_bits(8'hFF, 5);
        #30 n_rst = 1'b0;
        #20;
        chk("midrst_spi_in", 32'(SPI_in), 32'h00);
        chk("midrst_strobes", {shift_SPI, byte_done, pixel_wr}, 32'h0);
        n_rst = 1'b1;
        repeat (5) @(negedge clk);
        clr();
        spi_byte(8'hA5);
        chk("midrst_a5", 32'(SPI_in), 32'hA5);
        chk("midrst_bd", n_bd, 1);

        // Edge timing with SS low
        do_reset();
        SS = 1'b0;
        repeat (5) @(negedge clk);
        SCK = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            s[k] = shift_SPI;
        end
        chk("rise_lat", 32'(s), 32'b00100);
        SCK = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            s[k] = sig_edge;
        end
        chk("fall_lat", 32'(s), 32'b00100);

        // Edge gating with SS high
        SS = 1'b1;
        repeat (5) @(negedge clk);
        s = '0;
        SCK = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            s[0] = s[0] | shift_SPI | sig_edge;
        end
        SCK = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            s[0] = s[0] | shift_SPI | sig_edge;
        end
        chk("ss_gate", 32'(s[0]), 32'h0);

        // Cost command and ignored byte
        do_reset();
        SS = 1'b0;
        repeat (5) @(negedge clk);
        spi_byte(8'h01);
        chk("cost_bd", n_bd, 1);
        chk("cost_cnt", n_cost, 1);
        chk("cost_lag", cost_cyc - bd_cyc, 1);
        chk("cost_spi_in", 32'(cost_spi), 32'h01);
        spi_byte(8'h7E);
        chk("ign_cost", n_cost, 1);
        spi_byte(8'h01);
        chk("ign_cmd_state", n_cost, 2);
        chk("ign_no_wr", n_wr, 0);

        // Image load
        do_reset();
        SS = 1'b0;
        repeat (5) @(negedge clk);
        spi_byte(8'h02);
        spi_byte(8'h10);
        spi_byte(8'h20);
        spi_byte(8'h30);
        spi_byte(8'h40);
        chk("img_wr_cnt", n_wr, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("img_addr%0d", i), 32'(wa[i]), i);
            chk($sformatf("img_data%0d", i), 32'(wd[i]), 32'h10 * (i + 1));
        end
        chk("img_loaded", n_img, 1);
        chk("img_lag", img_cyc - wr_cyc, 1);
        spi_byte(8'h01);
        chk("img_back_cmd", n_cost, 1);
        chk("img_no_extra_wr", n_wr, 4);

        // Abort mid-load
        do_reset();
        SS = 1'b0;
        repeat (5) @(negedge clk);
        spi_byte(8'h02);
        spi_byte(8'h11);
        spi_byte(8'h22);
        SS = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_wr", n_wr, 2);
        chk("abort_d1", 32'(wd[1]), 32'h22);
        chk("abort_img", n_img, 0);
        SS = 1'b0;
        repeat (5) @(negedge clk);
        spi_byte(8'h01);
        chk("abort_cost", n_cost, 1);
        chk("abort_no_wr", n_wr, 2);

        // Partial byte discard
        do_reset();
        SS = 1'b0;
        repeat (5) @(negedge clk);
        spi_bits(8'hFF, 6);
        SS = 1'b1;
        repeat (10) @(negedge clk);
        SS = 1'b0;
        repeat (10) @(negedge clk);
        spi_byte(8'h3C);
        chk("part_spi_in", 32'(SPI_in), 32'h3C);
        chk("part_bd", n_bd, 1);

        chk("strobe_overlap", n_ovl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
